// File: rtl/snitch_shared_acc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snitch_shared_acc_arbiter
//  Description : Shares one offload accelerator among several cores. Requests
//                are round-robin arbitrated onto the single unit port and the
//                winning port index is kept in an in-order tag FIFO so each
//                response is routed back to the core that issued it.
//  Revision    : 1.0 - initial release
// ============================================================================
module snitch_shared_acc_arbiter #(
    parameter int unsigned NR_PORTS        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned REQ_WIDTH       = 32,
    parameter int unsigned RESP_WIDTH      = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_PORTS*REQ_WIDTH-1:0]    core_req_i,
    input  logic [NR_PORTS-1:0]              core_req_valid_i,
    output logic [NR_PORTS-1:0]              core_req_ready_o,
    output logic [NR_PORTS*RESP_WIDTH-1:0]   core_resp_o,
    output logic [NR_PORTS-1:0]              core_resp_valid_o,
    input  logic [NR_PORTS-1:0]              core_resp_ready_i,
    output logic [REQ_WIDTH-1:0]             acc_req_o,
    output logic                             acc_req_valid_o,
    input  logic                             acc_req_ready_i,
    input  logic [RESP_WIDTH-1:0]            acc_resp_i,
    input  logic                             acc_resp_valid_i,
    output logic                             acc_resp_ready_o
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int          C_NP  = int'(NR_PORTS);
    localparam logic [CNT_W-1:0] C_MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NR_PORTS - 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    // IDLE: free to re-arbitrate; HOLD: a presented request awaits acceptance
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } lock_state_t;

    lock_state_t      r_state;
    lock_state_t      w_state_next;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_winner;
    logic             w_req_pending;
    logic             w_req_valid;
    logic             w_req_hs;
    logic [REQ_WIDTH-1:0] w_req_payload;

    logic [IDX_W-1:0] r_tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_resp_ready;
    logic             w_pop;

    // Round-robin search: first valid port at or after the RR pointer
    always_comb begin
        w_rr_idx = r_rr_ptr;
        for (int i = C_NP - 1; i >= 0; i--) begin
            if (core_req_valid_i[(int'(r_rr_ptr) + i) % C_NP]) begin
                w_rr_idx = IDX_W'((int'(r_rr_ptr) + i) % C_NP);
            end
        end
    end

    assign w_winner      = (r_state == ST_HOLD) ? r_lock_idx : w_rr_idx;
    assign w_req_pending = (r_state == ST_HOLD) | (|core_req_valid_i);
    assign w_full        = (r_count == C_MAX_CNT);
    assign w_empty       = (r_count == '0);
    assign w_req_valid   = rst_ni & w_req_pending & ~w_full;
    assign w_req_hs      = w_req_valid & acc_req_ready_i;
    assign w_head        = r_tag_mem[r_rd_ptr];
    assign w_resp_ready  = rst_ni & ~w_empty & core_resp_ready_i[w_head];
    assign w_pop         = acc_resp_valid_i & w_resp_ready;

    // Request mux and per-core ready/response-valid decode
    always_comb begin
        w_req_payload     = '0;
        core_req_ready_o  = '0;
        core_resp_valid_o = '0;
        for (int i = 0; i < C_NP; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_req_payload       = core_req_i[i*REQ_WIDTH +: REQ_WIDTH];
                core_req_ready_o[i] = w_req_hs;
            end
            if (w_head == IDX_W'(i)) begin
                core_resp_valid_o[i] = rst_ni & acc_resp_valid_i & ~w_empty;
            end
        end
    end

    assign acc_req_o        = rst_ni ? w_req_payload : '0;
    assign acc_req_valid_o  = w_req_valid;
    assign acc_resp_ready_o = w_resp_ready;
    assign core_resp_o      = {NR_PORTS{rst_ni ? acc_resp_i : {RESP_WIDTH{1'b0}}}};

    // Lock next-state: hold the winner while the unit stalls a presented request
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req_valid && !acc_req_ready_i) w_state_next = ST_HOLD;
            ST_HOLD: if (acc_req_ready_i)                 w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Lock state, locked winner and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_req_valid && !acc_req_ready_i) begin
                r_lock_idx <= w_winner;
            end
            if (w_req_hs) begin
                r_rr_ptr <= (w_winner == C_LAST_IDX) ? '0 : w_winner + 1'b1;
            end
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_req_hs) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_req_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read when the count says valid
    always_ff @(posedge clk_i) begin
        if (w_req_hs) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
        end
    end

    // Protocol checks
    a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (acc_req_valid_o && !acc_req_ready_i) |=> (acc_req_valid_o && $stable(acc_req_o)));
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_req_hs |-> !w_full);
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        acc_resp_valid_i |-> !w_empty);

endmodule
`default_nettype wire

// File: tb/tb_snitch_shared_acc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snitch_shared_acc_arbiter
//  Description : Self-checking bench for snitch_shared_acc_arbiter using a
//                queue-based reference model, directed scenarios and a
//                randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snitch_shared_acc_arbiter;

    localparam int N    = 4;
    localparam int MAXO = 4;
    localparam int RW   = 32;
    localparam int SW   = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N*RW-1:0]   core_req_i;
    logic [N-1:0]      core_req_valid_i;
    logic [N-1:0]      core_req_ready_o;
    logic [N*SW-1:0]   core_resp_o;
    logic [N-1:0]      core_resp_valid_o;
    logic [N-1:0]      core_resp_ready_i;
    logic [RW-1:0]     acc_req_o;
    logic              acc_req_valid_o;
    logic              acc_req_ready_i;
    logic [SW-1:0]     acc_resp_i;
    logic              acc_resp_valid_i;
    logic              acc_resp_ready_o;

    snitch_shared_acc_arbiter #(
        .NR_PORTS(N), .MAX_OUTSTANDING(MAXO), .REQ_WIDTH(RW), .RESP_WIDTH(SW)
    ) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_req_valid_i(core_req_valid_i),
        .core_req_ready_o(core_req_ready_o),
        .core_resp_o(core_resp_o), .core_resp_valid_o(core_resp_valid_o),
        .core_resp_ready_i(core_resp_ready_i),
        .acc_req_o(acc_req_o), .acc_req_valid_o(acc_req_valid_o),
        .acc_req_ready_i(acc_req_ready_i),
        .acc_resp_i(acc_resp_i), .acc_resp_valid_i(acc_resp_valid_i),
        .acc_resp_ready_o(acc_resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: RR pointer, lock flag, queue of outstanding tags
    int m_ptr;
    bit m_locked;
    int m_lock_idx;
    int m_q[$];
    bit last_req_hs;
    int last_win;
    bit last_resp_hs;

    bit            pend  [N];
    logic [RW-1:0] pdata [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge
    task automatic cycle();
        int  win;
        bit  found;
        bit  any;
        bit  full;
        bit  empty;
        bit  ev;
        bit  erv;
        int  tgt;
        int  tmp;
        logic [N-1:0] erdy;
        logic [N-1:0] ervld;
        #1;
        if (!rst_ni) begin
            chk("rst_req_valid",  128'(acc_req_valid_o),   128'(0));
            chk("rst_req_ready",  128'(core_req_ready_o),  128'(0));
            chk("rst_resp_valid", 128'(core_resp_valid_o), 128'(0));
            chk("rst_resp_ready", 128'(acc_resp_ready_o),  128'(0));
            chk("rst_req_data",   128'(acc_req_o),         128'(0));
            chk("rst_resp_data",  128'(core_resp_o),       128'(0));
            m_ptr = 0; m_locked = 0; m_lock_idx = 0; m_q.delete();
            last_req_hs = 0; last_resp_hs = 0;
            @(posedge clk_i);
            @(negedge clk_i);
            return;
        end
        any   = m_locked || (core_req_valid_i != '0);
        win   = m_lock_idx;
        found = m_locked;
        for (int k = 0; k < N; k++) begin
            if (!found && core_req_valid_i[(m_ptr + k) % N]) begin
                win = (m_ptr + k) % N;
                found = 1;
            end
        end
        full  = (m_q.size() == MAXO);
        empty = (m_q.size() == 0);
        ev    = any && !full;
        erdy  = (ev && acc_req_ready_i) ? N'(1 << win) : '0;
        chk("req_valid", 128'(acc_req_valid_o), 128'(ev));
        if (ev) chk("req_payload", 128'(acc_req_o), 128'(core_req_i[win*RW +: RW]));
        chk("req_ready", 128'(core_req_ready_o), 128'(erdy));
        tgt   = empty ? 0 : m_q[0];
        ervld = (acc_resp_valid_i && !empty) ? N'(1 << tgt) : '0;
        erv   = !empty && core_resp_ready_i[tgt];
        chk("resp_valid", 128'(core_resp_valid_o), 128'(ervld));
        chk("resp_ready", 128'(acc_resp_ready_o),  128'(erv));
        chk("resp_data",  128'(core_resp_o),       128'({N{acc_resp_i}}));
        last_req_hs  = ev && acc_req_ready_i;
        last_win     = win;
        last_resp_hs = acc_resp_valid_i && erv;
        @(posedge clk_i);
        if (last_resp_hs) tmp = m_q.pop_front();
        if (last_req_hs) begin
            m_q.push_back(win);
            m_ptr    = (win + 1) % N;
            m_locked = 0;
        end else begin
            m_locked   = ev;
            m_lock_idx = win;
        end
        @(negedge clk_i);
    endtask

    task automatic set_req(input int port, input logic [RW-1:0] data);
        core_req_i[port*RW +: RW] = data;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        core_req_valid_i  = '1;
        acc_req_ready_i   = 1'b1;
        acc_resp_valid_i  = 1'b1;
        core_resp_ready_i = '1;
        core_req_i        = {N{32'hDEAD_BEEF}};
        acc_resp_i        = 32'h1234_5678;
        cycle();
        cycle();
        core_req_valid_i  = '0;
        acc_req_ready_i   = 1'b0;
        acc_resp_valid_i  = 1'b0;
        core_resp_ready_i = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        rst_ni = 1'b1;
    endtask

    task automatic rand_cycle();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                pend[i]  = 1;
                pdata[i] = $urandom;
            end
            core_req_valid_i[i] = pend[i];
            set_req(i, pdata[i]);
        end
        acc_req_ready_i   = ($urandom_range(0, 3) != 0);
        acc_resp_valid_i  = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
        acc_resp_i        = $urandom;
        core_resp_ready_i = N'($urandom);
        cycle();
        if (last_req_hs) pend[last_win] = 0;
    endtask

    initial begin
        int hs;
        rst_ni = 1'b0;
        core_req_i = '0; core_req_valid_i = '0; core_resp_ready_i = '0;
        acc_req_ready_i = 1'b0; acc_resp_i = '0; acc_resp_valid_i = 1'b0;
        m_ptr = 0; m_locked = 0; m_lock_idx = 0;
        @(negedge clk_i);

        // Single core 2 issues three requests, then receives three responses
        do_reset();
        hs = 0;
        acc_req_ready_i = 1'b1;
        core_req_valid_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_req(2, 32'hA0 + k);
            cycle();
            if (last_req_hs && last_win == 2) hs++;
        end
        chk("s1_handshakes", 128'(hs), 128'(3));
        core_req_valid_i  = '0;
        acc_resp_valid_i  = 1'b1;
        core_resp_ready_i = '1;
        for (int k = 0; k < 3; k++) begin
            acc_resp_i = 32'hC0 + k;
            #1 chk("s1_resp_route", 128'(core_resp_valid_o), 128'(4'b0100));
            cycle();
        end
        acc_resp_valid_i = 1'b0;
        cycle();

        // All four cores valid every cycle: strict rotation 0,1,2,3,...
        do_reset();
        acc_req_ready_i   = 1'b1;
        core_resp_ready_i = '1;
        core_req_valid_i  = '1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) set_req(i, $urandom);
            acc_resp_valid_i = (m_q.size() != 0);
            acc_resp_i = $urandom;
            cycle();
            chk("s2_grant", 128'(last_win), 128'(k % N));
        end

        // Unit stalls with core 1 presented; core 0 arrives later but must wait
        do_reset();
        core_req_valid_i = 4'b0010;
        set_req(1, 32'h1111_0001);
        set_req(0, 32'h0000_0AAA);
        for (int k = 0; k < 5; k++) begin
            if (k >= 1) core_req_valid_i = 4'b0011;
            #1 chk("s3_hold_payload", 128'(acc_req_o), 128'(32'h1111_0001));
            cycle();
        end
        acc_req_ready_i = 1'b1;
        #1 chk("s3_release_ready", 128'(core_req_ready_o), 128'(4'b0010));
        cycle();
        core_req_valid_i = 4'b0001;
        #1 chk("s3_next_winner", 128'(core_req_ready_o), 128'(4'b0001));
        cycle();

        // Fill the tag FIFO; a same-cycle pop must not unblock the push
        do_reset();
        acc_req_ready_i  = 1'b1;
        core_req_valid_i = 4'b0001;
        set_req(0, 32'h5555_0000);
        for (int k = 0; k < MAXO; k++) cycle();
        #1 chk("s4_full_block", 128'(acc_req_valid_o), 128'(0));
        cycle();
        acc_resp_valid_i  = 1'b1;
        core_resp_ready_i = '1;
        #1 chk("s4_pop_no_unblock", 128'(acc_req_valid_o), 128'(0));
        chk("s4_pop_ready", 128'(acc_resp_ready_o), 128'(1));
        cycle();
        acc_resp_valid_i = 1'b0;
        #1 chk("s4_resume", 128'(acc_req_valid_o), 128'(1));
        cycle();

        // Response for core 3 back-pressured for four cycles
        do_reset();
        acc_req_ready_i  = 1'b1;
        core_req_valid_i = 4'b1000;
        set_req(3, 32'h3333_3333);
        cycle();
        core_req_valid_i  = '0;
        acc_resp_valid_i  = 1'b1;
        acc_resp_i        = 32'hBEEF_0003;
        core_resp_ready_i = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            #1 chk("s5_stall_ready", 128'(acc_resp_ready_o), 128'(0));
            chk("s5_stall_route", 128'(core_resp_valid_o), 128'(4'b1000));
            cycle();
        end
        core_resp_ready_i = '1;
        #1 chk("s5_deliver", 128'(acc_resp_ready_o), 128'(1));
        cycle();
        acc_resp_valid_i = 1'b0;

        // Asynchronous reset with three requests outstanding
        do_reset();
        acc_req_ready_i  = 1'b1;
        core_req_valid_i = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_req(2, 32'h7000 + k);
            cycle();
        end
        core_req_valid_i  = '1;
        acc_resp_valid_i  = 1'b1;
        core_resp_ready_i = '1;
        rst_ni = 1'b0;
        #1 chk("s6_async_req_valid", 128'(acc_req_valid_o), 128'(0));
        chk("s6_async_resp_valid", 128'(core_resp_valid_o), 128'(0));
        chk("s6_async_req_ready", 128'(core_req_ready_o), 128'(0));
        cycle();
        rst_ni = 1'b1;
        acc_resp_valid_i = 1'b0;
        #1 chk("s6_rr_restart", 128'(core_req_ready_o), 128'(4'b0001));
        chk("s6_fifo_empty", 128'(acc_resp_ready_o), 128'(0));
        cycle();

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) rand_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
